// File: rtl/p_dma.sv
// p_dma: word-copy DMA engine with a bus-target register port (SRC/DST/LEN/CTRL)
// and a bus-initiator copy port. Define P_DMA_IRQ_EN to add the irq output.
module p_dma #(
  parameter int XLEN         = 32,
  parameter int MAX_LEN_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  input  logic                    cfg_rw,
  input  logic [XLEN-1:0]         cfg_addr,
  input  logic [XLEN-1:0]         cfg_wdata,
  input  logic [XLEN/8-1:0]       cfg_wstrb,
  input  logic [2:0]              cfg_size,
  output logic                    cfg_ready,
  output logic [XLEN-1:0]         cfg_rdata,
  output logic                    cfg_denied,
  output logic                    cfg_corrupt,
  output logic                    bus_valid,
  output logic                    bus_rw,
  output logic [XLEN-1:0]         bus_addr,
  output logic [XLEN-1:0]         bus_wdata,
  output logic [XLEN/8-1:0]       bus_wstrb,
  output logic [2:0]              bus_size,
  input  logic                    bus_ready,
  input  logic [XLEN-1:0]         bus_rdata,
  input  logic                    bus_denied,
  input  logic                    bus_corrupt
`ifdef P_DMA_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam logic [XLEN-1:0]         WORD_STEP = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [MAX_LEN_BITS-1:0] LEN_ONE   = {{(MAX_LEN_BITS-1){1'b0}}, 1'b1};
  localparam logic [MAX_LEN_BITS-1:0] LEN_ZERO  = {MAX_LEN_BITS{1'b0}};
  localparam logic [XLEN-1:0]         XZERO     = {XLEN{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_GAP = 3'd2,
    S_WR_REQ = 3'd3,
    S_WR_GAP = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [XLEN-1:0]         src_r, src_s, dst_r, dst_s;
  logic [MAX_LEN_BITS-1:0] len_r, len_s, count_r, count_s;
  logic [XLEN-1:0]         src_ptr_r, src_ptr_s, dst_ptr_r, dst_ptr_s;
  logic [XLEN-1:0]         data_r, data_s;
  logic                    done_r, done_s, error_r, error_s;
  logic                    cfg_ready_r, cfg_ready_s, cfg_denied_r, cfg_denied_s;
  logic [XLEN-1:0]         cfg_rdata_r, cfg_rdata_s;
  logic                    bus_valid_r, bus_valid_s, bus_rw_r, bus_rw_s;
  logic [XLEN-1:0]         bus_addr_r, bus_addr_s, bus_wdata_r, bus_wdata_s;
  logic [XLEN/8-1:0]       bus_wstrb_r, bus_wstrb_s;
  logic [2:0]              bus_size_r;
  logic [XLEN-1:0]         status_s;
  logic                    busy_s, accept_s, bad_req_s, bus_err_s;
  logic                    unused_s;
`ifdef P_DMA_IRQ_EN
  logic                    irq_en_r, irq_en_s, irq_r, irq_s;
`endif

  assign busy_s    = (state_r != S_IDLE);
  assign accept_s  = cfg_valid & ~cfg_ready_r;
  assign bus_err_s = bus_denied | bus_corrupt;
  assign bad_req_s = (cfg_size != 3'd2)
                   | (cfg_rw & (cfg_wstrb != {(XLEN/8){1'b1}}))
                   | (cfg_rw & busy_s & (cfg_addr[3:2] != 2'd3));
  assign unused_s  = ^{cfg_addr[XLEN-1:4], cfg_addr[1:0]};

  // Register port decode, copy FSM and next values of every registered output.
  always_comb begin
    state_s      = state_r;
    src_s        = src_r;
    dst_s        = dst_r;
    len_s        = len_r;
    count_s      = count_r;
    src_ptr_s    = src_ptr_r;
    dst_ptr_s    = dst_ptr_r;
    data_s       = data_r;
    done_s       = done_r;
    error_s      = error_r;
    cfg_ready_s  = 1'b0;
    cfg_denied_s = 1'b0;
    cfg_rdata_s  = XZERO;
`ifdef P_DMA_IRQ_EN
    irq_en_s     = irq_en_r;
    status_s     = {{(XLEN-4){1'b0}}, irq_en_r, error_r, done_r, busy_s};
`else
    status_s     = {{(XLEN-4){1'b0}}, 1'b0, error_r, done_r, busy_s};
`endif

    if (accept_s) begin
      cfg_ready_s = 1'b1;
      if (bad_req_s) begin
        cfg_denied_s = 1'b1;
      end else if (cfg_rw) begin
        case (cfg_addr[3:2])
          2'd0: src_s = {cfg_wdata[XLEN-1:2], 2'b00};
          2'd1: dst_s = {cfg_wdata[XLEN-1:2], 2'b00};
          2'd2: len_s = cfg_wdata[MAX_LEN_BITS-1:0];
          2'd3: begin
`ifdef P_DMA_IRQ_EN
            irq_en_s = cfg_wdata[3];
`endif
            if (cfg_wdata[1]) begin
              done_s  = 1'b0;
              error_s = 1'b0;
            end else begin
              done_s  = done_r;
            end
            // Start while busy is silently ignored; a zero-length start completes at once.
            if (cfg_wdata[0] && !busy_s) begin
              done_s    = 1'b0;
              error_s   = 1'b0;
              src_ptr_s = src_r;
              dst_ptr_s = dst_r;
              count_s   = len_r;
              if (len_r == LEN_ZERO) begin
                done_s = 1'b1;
              end else begin
                state_s = S_RD_REQ;
              end
            end else begin
              state_s = state_r;
            end
          end
          default: src_s = src_r;
        endcase
      end else begin
        case (cfg_addr[3:2])
          2'd0:    cfg_rdata_s = src_r;
          2'd1:    cfg_rdata_s = dst_r;
          2'd2:    cfg_rdata_s = {{(XLEN-MAX_LEN_BITS){1'b0}}, len_r};
          2'd3:    cfg_rdata_s = status_s;
          default: cfg_rdata_s = XZERO;
        endcase
      end
    end else begin
      cfg_ready_s = 1'b0;
    end

    case (state_r)
      S_IDLE: state_s = state_s;
      S_RD_REQ: begin
        if (bus_ready && bus_err_s) begin
          error_s = 1'b1;
          done_s  = 1'b1;
          state_s = S_IDLE;
        end else if (bus_ready) begin
          data_s  = bus_rdata;
          state_s = S_RD_GAP;
        end else begin
          state_s = S_RD_REQ;
        end
      end
      S_RD_GAP: state_s = S_WR_REQ;
      S_WR_REQ: begin
        if (bus_ready && bus_err_s) begin
          error_s = 1'b1;
          done_s  = 1'b1;
          state_s = S_IDLE;
        end else if (bus_ready) begin
          src_ptr_s = src_ptr_r + WORD_STEP;
          dst_ptr_s = dst_ptr_r + WORD_STEP;
          count_s   = count_r - LEN_ONE;
          state_s   = S_WR_GAP;
        end else begin
          state_s = S_WR_REQ;
        end
      end
      S_WR_GAP: state_s = (count_r == LEN_ZERO) ? S_FINISH : S_RD_REQ;
      S_FINISH: begin
        done_s  = 1'b1;
        state_s = S_IDLE;
      end
      default: state_s = S_IDLE;
    endcase

    // Bus outputs follow the next state so they are registered yet line up with it.
    if (state_s == S_RD_REQ) begin
      bus_valid_s = 1'b1;
      bus_rw_s    = 1'b0;
      bus_addr_s  = src_ptr_s;
      bus_wdata_s = XZERO;
      bus_wstrb_s = {(XLEN/8){1'b0}};
    end else if (state_s == S_WR_REQ) begin
      bus_valid_s = 1'b1;
      bus_rw_s    = 1'b1;
      bus_addr_s  = dst_ptr_s;
      bus_wdata_s = data_s;
      bus_wstrb_s = {(XLEN/8){1'b1}};
    end else begin
      bus_valid_s = 1'b0;
      bus_rw_s    = 1'b0;
      bus_addr_s  = XZERO;
      bus_wdata_s = XZERO;
      bus_wstrb_s = {(XLEN/8){1'b0}};
    end

`ifdef P_DMA_IRQ_EN
    irq_s = irq_en_s & (done_s | error_s);
`endif
  end

  // State and output registers; reset also drops bus_valid asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      src_r        <= XZERO;
      dst_r        <= XZERO;
      len_r        <= LEN_ZERO;
      count_r      <= LEN_ZERO;
      src_ptr_r    <= XZERO;
      dst_ptr_r    <= XZERO;
      data_r       <= XZERO;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      cfg_ready_r  <= 1'b0;
      cfg_denied_r <= 1'b0;
      cfg_rdata_r  <= XZERO;
      bus_valid_r  <= 1'b0;
      bus_rw_r     <= 1'b0;
      bus_addr_r   <= XZERO;
      bus_wdata_r  <= XZERO;
      bus_wstrb_r  <= {(XLEN/8){1'b0}};
      bus_size_r   <= 3'd0;
`ifdef P_DMA_IRQ_EN
      irq_en_r     <= 1'b0;
      irq_r        <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      src_r        <= src_s;
      dst_r        <= dst_s;
      len_r        <= len_s;
      count_r      <= count_s;
      src_ptr_r    <= src_ptr_s;
      dst_ptr_r    <= dst_ptr_s;
      data_r       <= data_s;
      done_r       <= done_s;
      error_r      <= error_s;
      cfg_ready_r  <= cfg_ready_s;
      cfg_denied_r <= cfg_denied_s;
      cfg_rdata_r  <= cfg_rdata_s;
      bus_valid_r  <= bus_valid_s;
      bus_rw_r     <= bus_rw_s;
      bus_addr_r   <= bus_addr_s;
      bus_wdata_r  <= bus_wdata_s;
      bus_wstrb_r  <= bus_wstrb_s;
      bus_size_r   <= 3'd2;
`ifdef P_DMA_IRQ_EN
      irq_en_r     <= irq_en_s;
      irq_r        <= irq_s;
`endif
    end
  end

  assign cfg_ready   = cfg_ready_r;
  assign cfg_rdata   = cfg_rdata_r;
  assign cfg_denied  = cfg_denied_r;
  assign cfg_corrupt = 1'b0;
  assign bus_valid   = bus_valid_r;
  assign bus_rw      = bus_rw_r;
  assign bus_addr    = bus_addr_r;
  assign bus_wdata   = bus_wdata_r;
  assign bus_wstrb   = bus_wstrb_r;
  assign bus_size    = bus_size_r;
`ifdef P_DMA_IRQ_EN
  assign irq         = irq_r;
`endif

endmodule

// File: tb/tb_p_dma.sv
// Self-checking bench for p_dma: register-port vector table, bus responder with a
// scoreboard of expected copy transactions, and hand-written multi-cycle sequences.
module tb_p_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid, cfg_rw;
  logic [31:0] cfg_addr, cfg_wdata;
  logic [3:0]  cfg_wstrb;
  logic [2:0]  cfg_size;
  logic        cfg_ready, cfg_denied, cfg_corrupt;
  logic [31:0] cfg_rdata;
  logic        bus_valid, bus_rw;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [2:0]  bus_size;
  logic        bus_ready, bus_denied, bus_corrupt;
  logic [31:0] bus_rdata;
`ifdef P_DMA_IRQ_EN
  logic        irq;
  localparam logic [31:0] IRQ_BIT = 32'h0000_0008;
`else
  localparam logic [31:0] IRQ_BIT = 32'h0000_0000;
`endif

  p_dma #(.XLEN(32), .MAX_LEN_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_rw(cfg_rw), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_wstrb(cfg_wstrb), .cfg_size(cfg_size), .cfg_ready(cfg_ready), .cfg_rdata(cfg_rdata),
    .cfg_denied(cfg_denied), .cfg_corrupt(cfg_corrupt),
    .bus_valid(bus_valid), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_size(bus_size), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .bus_denied(bus_denied), .bus_corrupt(bus_corrupt)
`ifdef P_DMA_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_txn_t;

  typedef struct {
    string       name;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic [31:0] exp_rdata;
    logic        exp_denied;
  } cfg_vec_t;

  bus_txn_t exp_q[$];
  bus_txn_t txn;
  cfg_vec_t vecs[$];

  int passed = 0;
  int total  = 0;
  int lat = 0;
  int deny_rd_idx = -1;
  int rd_cnt = 0;
  int idle_run = 0;
  int wait_cnt = 0;
  bit first_txn = 1'b1;
  bit prev_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add_vec(input string n, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [2:0] sz, input logic [31:0] er, input logic ed);
    cfg_vec_t v;
    v.name = n; v.rw = rw; v.addr = a; v.wdata = wd; v.wstrb = ws; v.size = sz;
    v.exp_rdata = er; v.exp_denied = ed;
    vecs.push_back(v);
  endtask

  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    bus_txn_t t;
    for (int i = 0; i < len; i++) begin
      t.rw = 1'b0; t.addr = src + 32'(4 * i); t.data = 32'h0;
      exp_q.push_back(t);
      t.rw = 1'b1; t.addr = dst + 32'(4 * i); t.data = mem_word(src + 32'(4 * i));
      exp_q.push_back(t);
    end
  endtask

  // Bus target model: responds after `lat` waiting cycles and scores each handshake.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      bus_ready = 1'b0; bus_denied = 1'b0; bus_rdata = 32'h0;
      wait_cnt = 0; prev_valid = 1'b0;
    end else begin
      if (bus_valid && !prev_valid && !first_txn) check("bus_gap", idle_run, 32'd1);
      if (!bus_valid) idle_run++;
      prev_valid = bus_valid;
      if (bus_ready) begin
        bus_ready = 1'b0; bus_denied = 1'b0;
      end else if (bus_valid) begin
        if (wait_cnt < lat) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL bus_unexpected: request rw=%0b at %h, none expected", bus_rw, bus_addr);
          end else begin
            txn = exp_q.pop_front();
            check("bus_rw", bus_rw, txn.rw);
            check("bus_addr", bus_addr, txn.addr);
            check("bus_wstrb", bus_wstrb, txn.rw ? 32'hF : 32'h0);
            check("bus_size", bus_size, 32'd2);
            if (txn.rw) check("bus_wdata", bus_wdata, txn.data);
          end
          if (!bus_rw) begin
            bus_rdata  = mem_word(bus_addr);
            bus_denied = (rd_cnt == deny_rd_idx);
            rd_cnt++;
          end
          bus_ready = 1'b1; idle_run = 0; first_txn = 1'b0;
        end
      end
    end
  end

  task automatic cfg_acc(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] size,
                         output logic [31:0] rdata, output logic denied);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_rw = rw; cfg_addr = addr; cfg_wdata = wdata;
    cfg_wstrb = wstrb; cfg_size = size;
    @(negedge clk);
    check("cfg_ready", cfg_ready, 32'd1);
    rdata = cfg_rdata; denied = cfg_denied;
    cfg_valid = 1'b0;
  endtask

  task automatic reg_wr(input string name, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r; logic d;
    cfg_acc(1'b1, addr, data, 4'hF, 3'd2, r, d);
    check({name, "_denied"}, d, 32'd0);
  endtask

  task automatic reg_rd(input logic [31:0] addr, output logic [31:0] data);
    logic d;
    cfg_acc(1'b0, addr, 32'h0, 4'h0, 3'd2, data, d);
  endtask

  task automatic expect_reg(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    reg_rd(addr, r);
    check(name, r, exp);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s; int n;
    n = 0;
    reg_rd(32'hC, s);
    while (s[0] && n < 200) begin
      reg_rd(32'hC, s);
      n++;
    end
    check({name, "_idle"}, s[0], 32'd0);
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                            input logic [31:0] ctrl);
    reg_wr("src_wr", 32'h0, src);
    reg_wr("dst_wr", 32'h4, dst);
    reg_wr("len_wr", 32'h8, len);
    first_txn = 1'b1;
    reg_wr("start", 32'hC, ctrl);
  endtask

  initial begin
    logic [31:0] r;
    logic d;
    int n;
    reset = 1'b0; cfg_valid = 1'b0; cfg_rw = 1'b0; cfg_addr = 32'h0; cfg_wdata = 32'h0;
    cfg_wstrb = 4'h0; cfg_size = 3'd0;
    bus_ready = 1'b0; bus_denied = 1'b0; bus_corrupt = 1'b0; bus_rdata = 32'h0;
    #12;
    check("rst_cfg_ready", cfg_ready, 32'd0);
    check("rst_cfg_rdata", cfg_rdata, 32'd0);
    check("rst_bus_valid", bus_valid, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_size", bus_size, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    add_vec("src_wr",     1'b1, 32'h0,  32'h1234_5677, 4'hF, 3'd2, 32'h0,         1'b0);
    add_vec("src_rd",     1'b0, 32'h0,  32'h0,         4'h0, 3'd2, 32'h1234_5674, 1'b0);
    add_vec("dst_wr",     1'b1, 32'h4,  32'hFFFF_FFFF, 4'hF, 3'd2, 32'h0,         1'b0);
    add_vec("dst_rd",     1'b0, 32'h4,  32'h0,         4'h0, 3'd2, 32'hFFFF_FFFC, 1'b0);
    add_vec("len_wr",     1'b1, 32'h8,  32'hABCD_0005, 4'hF, 3'd2, 32'h0,         1'b0);
    add_vec("len_rd",     1'b0, 32'h8,  32'h0,         4'h0, 3'd2, 32'h0000_0005, 1'b0);
    add_vec("len_byte",   1'b1, 32'h8,  32'h0000_0007, 4'h1, 3'd2, 32'h0,         1'b1);
    add_vec("len_keep",   1'b0, 32'h8,  32'h0,         4'h0, 3'd2, 32'h0000_0005, 1'b0);
    add_vec("size_rd",    1'b0, 32'h0,  32'h0,         4'h0, 3'd0, 32'h0,         1'b1);
    add_vec("size_wr",    1'b1, 32'h0,  32'hFFFF_FFF0, 4'hF, 3'd1, 32'h0,         1'b1);
    add_vec("src_keep",   1'b0, 32'h0,  32'h0,         4'h0, 3'd2, 32'h1234_5674, 1'b0);
    add_vec("src_alias",  1'b0, 32'h10, 32'h0,         4'h0, 3'd2, 32'h1234_5674, 1'b0);
    add_vec("ctrl_bit3",  1'b1, 32'hC,  32'h0000_0008, 4'hF, 3'd2, 32'h0,         1'b0);
    add_vec("stat_bit3",  1'b0, 32'hC,  32'h0,         4'h0, 3'd2, IRQ_BIT,       1'b0);
    add_vec("ctrl_clr",   1'b1, 32'hC,  32'h0,         4'hF, 3'd2, 32'h0,         1'b0);
    add_vec("stat_zero",  1'b0, 32'hC,  32'h0,         4'h0, 3'd2, 32'h0,         1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      cfg_acc(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].size, r, d);
      check({vecs[i].name, "_denied"}, d, vecs[i].exp_denied);
      if (!vecs[i].rw && !vecs[i].exp_denied) check({vecs[i].name, "_rdata"}, r, vecs[i].exp_rdata);
    end

    // Three-word copy with one wait state per transaction.
    lat = 1;
    push_copy(32'h4000_0000, 32'h0000_0100, 3);
    start_copy(32'h4000_0000, 32'h0000_0100, 32'd3, 32'h1);
    wait_idle("copy3");
    check("copy3_q", exp_q.size(), 32'd0);
    expect_reg("copy3_status", 32'hC, 32'h2);

    // Zero-length start: done without any bus traffic.
    reg_wr("clr0", 32'hC, 32'h2);
    expect_reg("clr0_status", 32'hC, 32'h0);
    start_copy(32'h0000_0800, 32'h0000_0900, 32'd0, 32'h1);
    expect_reg("len0_status", 32'hC, 32'h2);
    repeat (6) @(negedge clk);
    check("len0_bus_valid", bus_valid, 32'd0);

    // Source pointer wraps past the top of the address space.
    lat = 0;
    push_copy(32'hFFFF_FFFC, 32'h0000_0200, 2);
    start_copy(32'hFFFF_FFFC, 32'h0000_0200, 32'd2, 32'h1);
    wait_idle("wrap");
    check("wrap_q", exp_q.size(), 32'd0);

    // Register accesses while busy.
    lat = 2;
    push_copy(32'h0000_1000, 32'h0000_5000, 4);
    start_copy(32'h0000_1000, 32'h0000_5000, 32'd4, 32'h1);
    cfg_acc(1'b1, 32'h0, 32'h0000_7000, 4'hF, 3'd2, r, d);
    check("busy_src_denied", d, 32'd1);
    expect_reg("busy_src_keep", 32'h0, 32'h0000_1000);
    cfg_acc(1'b1, 32'hC, 32'h1, 4'hF, 3'd2, r, d);
    check("busy_start_denied", d, 32'd0);
    cfg_acc(1'b1, 32'h8, 32'h9, 4'h1, 3'd2, r, d);
    check("busy_len_byte_denied", d, 32'd1);
    reg_rd(32'hC, r);
    check("busy_flag", r[0], 32'd1);
    wait_idle("busy");
    check("busy_q", exp_q.size(), 32'd0);
    expect_reg("busy_status", 32'hC, 32'h2);
    expect_reg("busy_len_keep", 32'h8, 32'h4);

    // Second read is refused: no write for it and nothing afterwards.
    lat = 0;
    rd_cnt = 0;
    deny_rd_idx = 1;
    push_copy(32'h0000_2000, 32'h0000_3000, 1);
    txn.rw = 1'b0; txn.addr = 32'h0000_2004; txn.data = 32'h0;
    exp_q.push_back(txn);
    start_copy(32'h0000_2000, 32'h0000_3000, 32'd3, 32'h1);
    wait_idle("deny");
    repeat (10) @(negedge clk);
    check("deny_q", exp_q.size(), 32'd0);
    check("deny_rd_cnt", rd_cnt, 32'd2);
    expect_reg("deny_status", 32'hC, 32'h6);
    reg_wr("deny_w1c", 32'hC, 32'h2);
    expect_reg("deny_status_clr", 32'hC, 32'h0);
    deny_rd_idx = -1;

`ifdef P_DMA_IRQ_EN
    push_copy(32'h0000_6000, 32'h0000_6100, 1);
    start_copy(32'h0000_6000, 32'h0000_6100, 32'd1, 32'h9);
    check("irq_low_at_start", irq, 32'd0);
    n = 0;
    while (!irq && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("irq_rise", irq, 32'd1);
    expect_reg("irq_status", 32'hC, 32'hA);
    reg_wr("irq_w1c", 32'hC, 32'h2);
    check("irq_clear", irq, 32'd0);
`endif

    // Reset asserted while the first write is pending.
    lat = 3;
    rd_cnt = 0;
    push_copy(32'h0000_3000, 32'h0000_3100, 1);
    start_copy(32'h0000_3000, 32'h0000_3100, 32'd2, 32'h1);
    n = 0;
    while (rd_cnt < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!bus_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_valid", bus_valid, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_valid", bus_valid, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    first_txn = 1'b1;
    expect_reg("rst_status", 32'hC, 32'h0);
    expect_reg("rst_src", 32'h0, 32'h0);
    expect_reg("rst_dst", 32'h4, 32'h0);
    expect_reg("rst_len", 32'h8, 32'h0);
    repeat (4) @(negedge clk);
    check("rst_bus_idle", bus_valid, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
